data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Shares one single-port data memory between two requesters: port 0 (CPU load/store stage) and port 1 (DMA/debug loader).
- Sits between the requesters and the data memory, which has a combinational read and a write on the rising clock edge.
- Arbitration is round-robin with a bounded hold, so one requester can stream back-to-back accesses without starving the other.
- Read data is returned registered, one cycle after the access.

Parameters:
- DATA_WIDTH, 32, width of data and address buses.
- HOLD_MAX, 4, maximum consecutive accesses by one owner while the other port is requesting; must be ≥1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  access request; held high until acked.
- we0 / we1  input  1  1 = write, 0 = read; qualified by req.
- addr0 / addr1  input  DATA_WIDTH  word address.
- wdata0 / wdata1  input  DATA_WIDTH  write data.
- ack0 / ack1  output  1  access performed this cycle (combinational from state and req).
- rvalid0 / rvalid1  output  1  registered; read data valid.
- rdata0 / rdata1  output  DATA_WIDTH  registered read data.
- mem_read_enable  output  1  to memory read_enable.
- mem_write_enable  output  1  to memory write_enable.
- mem_address  output  DATA_WIDTH  to memory address.
- mem_in_data  output  DATA_WIDTH  to memory in_data.
- mem_out_data  input  DATA_WIDTH  from memory out_data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=1, hold_cnt=0.
  - rvalid0/1=0, rdata0/1=0.
  - All mem_* outputs and acks are 0, since they are derived from IDLE.
- States: IDLE, OWN0, OWN1, held in a registered owner field.
- IDLE:
  - No memory access; all mem_* outputs are 0.
  - req0 only → OWN0. req1 only → OWN1.
  - Both → the port ≠ last_grant, so port 0 wins first after reset.
  - Latency from IDLE: first ack one cycle after req rises.
- OWNx with reqx=1:
  - mem_address=addrx, mem_in_data=wdatax.
  - mem_write_enable=wex, mem_read_enable=~wex.
  - ackx=1; last_grant←x; hold_cnt←hold_cnt+1.
- Read acked in cycle T: rdatax←mem_out_data at the edge ending T; rvalidx=1 during T+1 only.
- Write acked in T: memory writes at the edge ending T; no rvalid.
- Leaving OWNx, evaluated every cycle:
  - reqx=0 and the other port requesting → OWN(other), hold_cnt←0. No access this cycle.
  - reqx=0 and no other request → IDLE, hold_cnt←0.
  - reqx=1 and hold_cnt==HOLD_MAX-1 and the other port requesting → the access still completes this cycle, then OWN(other), hold_cnt←0.
  - reqx=1 and the other port idle → stay in OWNx. hold_cnt saturates at HOLD_MAX-1; no forced switch.
- Requester rule: after ackx, the requester may change addr/we/wdata or drop req next cycle. Dropping req for an access not yet acked is allowed; the access is cancelled with no side effect.
- Exactly one ack is asserted per cycle at most. The non-owner's ack, rvalid and memory drive are 0.
- Same-address write then read from the two ports: the write acked at T is visible to the other port's read acked at T+1 or later.
- Reset asserted mid-access: the in-flight rvalid is killed immediately (asynchronous), and the FSM returns to IDLE. A memory write in the reset cycle does not occur, because write enable is gated by state.
- Width rule: addresses pass through unchanged. The memory indexes low bits; the arbiter does no range checking.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
  - hold counter width, $clog2(HOLD_MAX)+1.
- One sub-module: data_memory_arb_mux, a combinational owner-select mux for address/wdata/we.
- FSM, hold counter and read-return registers stay in the top module.

Test Plan:
- Reset then req0=1, we0=1, addr0=5, wdata0=0xDEAD_BEEF → ack0 in cycle 2; mem_write_enable=1, mem_address=5; no rvalid0.
- Both ports idle→ req0=req1=1 (reads, addr 5 and 6, memory preloaded) → port 0 acked first. rvalid0 next cycle with rdata0=0xDEADBEEF; port 1 served once port 0 releases.
- HOLD_MAX=4, req0 streams 6 reads, req1 asserted throughout → exactly 4 ack0, a switch to ack1, then port 0 resumes. No cycle has both acks set.
- req1 streams 10 writes with req0=0 → 10 consecutive ack1 with no gap after the first; hold_cnt saturates with no forced switch.
- Port 1 writes addr 9=0x1234 acked at T, then port 0 reads addr 9 → rdata0=0x1234.
- Assert reset low mid-read (cycle after ack0) → rvalid0 falls immediately, all mem_* go 0. After release, req0 is re-served from IDLE with 1-cycle latency.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: owner encoding and
// hold counter sizing.
package data_memory_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_e;

   // One extra bit so HOLD_MAX-1 always fits, including HOLD_MAX = 1.
   function automatic int unsigned hold_cnt_width(input int unsigned hold_max);
      return $clog2(hold_max) + 1;
   endfunction

endpackage

// File: rtl/data_memory_arb_mux.sv
// Owner-select mux: steers the owning port's address, write data and write
// flag toward the memory.
module data_memory_arb_mux #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  sel,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [DATA_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  we,
   output logic [DATA_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wdata
);

   always_comb begin
      we    = sel ? we1    : we0;
      addr  = sel ? addr1  : addr0;
      wdata = sel ? wdata1 : wdata0;
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter with bounded hold sharing one single-port data memory
// between the CPU (port 0) and a DMA/debug loader (port 1).
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned HOLD_MAX   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [DATA_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  mem_read_enable,
   output logic                  mem_write_enable,
   output logic [DATA_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_in_data,
   input  logic [DATA_WIDTH-1:0] mem_out_data
);

   localparam int unsigned      HoldW    = hold_cnt_width(HOLD_MAX);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_MAX - 1);

   state_e                  state;
   logic                    last_grant;
   logic [HoldW-1:0]        hold_cnt;
   logic                    access0;
   logic                    access1;
   logic                    access;
   logic                    mux_we;
   logic [DATA_WIDTH-1:0]   mux_addr;
   logic [DATA_WIDTH-1:0]   mux_wdata;

   // An access happens only when the owner is still requesting.
   assign access0 = (state == ST_OWN0) && req0;
   assign access1 = (state == ST_OWN1) && req1;
   assign access  = access0 || access1;
   assign ack0    = access0;
   assign ack1    = access1;

   data_memory_arb_mux #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_mux (
      .sel   (state == ST_OWN1),
      .we0   (we0),
      .we1   (we1),
      .addr0 (addr0),
      .addr1 (addr1),
      .wdata0(wdata0),
      .wdata1(wdata1),
      .we    (mux_we),
      .addr  (mux_addr),
      .wdata (mux_wdata)
   );

   assign mem_read_enable  = access && !mux_we;
   assign mem_write_enable = access && mux_we;
   assign mem_address      = access ? mux_addr  : '0;
   assign mem_in_data      = access ? mux_wdata : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         hold_cnt   <= '0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
      end else begin
         rvalid0 <= access0 && !we0;
         rvalid1 <= access1 && !we1;
         if (access0 && !we0) rdata0 <= mem_out_data;
         if (access1 && !we1) rdata1 <= mem_out_data;

         case (state)
            ST_IDLE: begin
               hold_cnt <= '0;
               if (req0 && (!req1 || last_grant)) state <= ST_OWN0;
               else if (req1)                     state <= ST_OWN1;
            end
            ST_OWN0: begin
               if (!req0) begin
                  hold_cnt <= '0;
                  state    <= req1 ? ST_OWN1 : ST_IDLE;
               end else begin
                  last_grant <= 1'b0;
                  if (req1 && hold_cnt == HoldLast) begin
                     state    <= ST_OWN1;
                     hold_cnt <= '0;
                  end else if (hold_cnt != HoldLast) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            ST_OWN1: begin
               if (!req1) begin
                  hold_cnt <= '0;
                  state    <= req0 ? ST_OWN0 : ST_IDLE;
               end else begin
                  last_grant <= 1'b1;
                  if (req0 && hold_cnt == HoldLast) begin
                     state    <= ST_OWN0;
                     hold_cnt <= '0;
                  end else if (hold_cnt != HoldLast) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               hold_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: per-port drivers, expected-access
// queue checked by an independent monitor, plus a behavioural memory.
module tb_data_memory_arbiter;

   localparam int unsigned DW = 32;

   typedef struct {
      logic          we;
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   typedef struct {
      logic          port;
      logic          we;
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          req0, req1, we0, we1;
   logic [DW-1:0] addr0, addr1, wdata0, wdata1;
   logic          ack0, ack1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          mem_read_enable, mem_write_enable;
   logic [DW-1:0] mem_address, mem_in_data, mem_out_data;

   logic [DW-1:0] mem [16];
   cmd_t          q0[$];
   cmd_t          q1[$];
   exp_t          exp_q[$];

   int            n_checks = 0;
   int            n_fail   = 0;
   logic          ack0_s   = 1'b0;
   logic          ack1_s   = 1'b0;
   logic          pend0    = 1'b0;
   logic          pend1    = 1'b0;
   logic [DW-1:0] pend0_d  = '0;
   logic [DW-1:0] pend1_d  = '0;

   data_memory_arbiter #(
      .DATA_WIDTH(DW),
      .HOLD_MAX  (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req0            (req0),
      .req1            (req1),
      .we0             (we0),
      .we1             (we1),
      .addr0           (addr0),
      .addr1           (addr1),
      .wdata0          (wdata0),
      .wdata1          (wdata1),
      .ack0            (ack0),
      .ack1            (ack1),
      .rvalid0         (rvalid0),
      .rvalid1         (rvalid1),
      .rdata0          (rdata0),
      .rdata1          (rdata1),
      .mem_read_enable (mem_read_enable),
      .mem_write_enable(mem_write_enable),
      .mem_address     (mem_address),
      .mem_in_data     (mem_in_data),
      .mem_out_data    (mem_out_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory: combinational read, write on the rising edge.
   assign mem_out_data = mem[mem_address[3:0]];
   always @(posedge clk) if (mem_write_enable) mem[mem_address[3:0]] <= mem_in_data;

   initial for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 + i;

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endfunction

   // Requesters hold req until acked, then advance to their next command.
   initial begin
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      forever begin
         @(posedge clk);
         #1;
         if (req0 && ack0_s && q0.size() > 0) q0.delete(0);
         if (req1 && ack1_s && q1.size() > 0) q1.delete(0);
         if (reset && q0.size() > 0) begin
            req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
         end else begin
            req0 = 1'b0; we0 = 1'b0;
         end
         if (reset && q1.size() > 0) begin
            req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
         end else begin
            req1 = 1'b0; we1 = 1'b0;
         end
      end
   end

   // Monitor: compares every ack against the next expected access, and every
   // cycle's rvalid/rdata against what the previous ack implies.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         ack0_s = ack0;
         ack1_s = ack1;
         if (!reset) begin
            pend0 = 1'b0;
            pend1 = 1'b0;
            chk("reset_outputs",
                {ack0, ack1, rvalid0, rvalid1, mem_read_enable, mem_write_enable}, '0);
            chk("reset_rdata", {rdata1, rdata0}, '0);
            chk("reset_mem_bus", {mem_address, mem_in_data}, '0);
         end else begin
            chk("rvalid0", rvalid0, pend0);
            if (pend0) chk("rdata0", rdata0, pend0_d);
            chk("rvalid1", rvalid1, pend1);
            if (pend1) chk("rdata1", rdata1, pend1_d);
            pend0 = 1'b0;
            pend1 = 1'b0;
            if (ack0 || ack1) begin
               chk("single_ack", ack0 && ack1, 1'b0);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b, required no ack",
                           ack0, ack1);
               end else begin
                  e = exp_q.pop_front();
                  chk("ack_port", ack1, e.port);
                  chk("mem_address", mem_address, e.addr);
                  chk("mem_write_enable", mem_write_enable, e.we);
                  chk("mem_read_enable", mem_read_enable, !e.we);
                  if (e.we) begin
                     chk("mem_in_data", mem_in_data, e.data);
                  end else if (e.port) begin
                     pend1 = 1'b1; pend1_d = e.data;
                  end else begin
                     pend0 = 1'b1; pend0_d = e.data;
                  end
               end
            end else begin
               chk("idle_mem_enables", {mem_read_enable, mem_write_enable}, 2'b00);
            end
         end
      end
   end

   task automatic send(input logic port, input logic we, input logic [DW-1:0] addr,
                       input logic [DW-1:0] data);
      cmd_t c;
      c.we = we; c.addr = addr; c.data = data;
      if (port) q1.push_back(c);
      else      q0.push_back(c);
   endtask

   task automatic expect_acc(input logic port, input logic we, input logic [DW-1:0] addr,
                             input logic [DW-1:0] data);
      exp_t e;
      e.port = port; e.we = we; e.addr = addr; e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
   endtask

   // Request rises in the first cycle, ack must appear in the second.
   task automatic check_latency(input string name, input logic port);
      @(negedge clk);
      #1 chk({name, "_no_ack_cycle1"}, port ? ack1 : ack0, 1'b0);
      @(negedge clk);
      #1 chk({name, "_ack_cycle2"}, port ? ack1 : ack0, 1'b1);
   endtask

   task automatic wait_ack(input string name, input logic port, input int max_cycles);
      int n = 0;
      while ((port ? ack1 : ack0) !== 1'b1 && n < max_cycles) begin
         @(negedge clk);
         #1 n++;
      end
      chk({name, "_ack_seen"}, port ? ack1 : ack0, 1'b1);
   endtask

   task automatic wait_drain(input string name, input int max_cycles);
      int n = 0;
      while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < max_cycles) begin
         @(negedge clk);
         #1 n++;
      end
      n_checks++;
      if (exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d expected accesses outstanding, required 0",
                  name, exp_q.size());
         exp_q.delete(); q0.delete(); q1.delete();
      end
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;

      // Single write from idle: ack in the second cycle, no read return.
      do_reset();
      send(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
      expect_acc(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
      check_latency("s1", 1'b0);
      wait_drain("s1", 20);

      // Simultaneous reads after reset: port 0 first, port 1 after release.
      do_reset();
      send(1'b0, 1'b0, 32'd5, '0);
      send(1'b1, 1'b0, 32'd6, '0);
      expect_acc(1'b0, 1'b0, 32'd5, 32'hDEAD_BEEF);
      expect_acc(1'b1, 1'b0, 32'd6, 32'hA5A5_0006);
      wait_drain("s2", 20);

      // Bounded hold: four port-0 reads, then port 1, then port 0 resumes.
      do_reset();
      for (int i = 0; i < 6; i++) send(1'b0, 1'b0, DW'(i), '0);
      send(1'b1, 1'b0, 32'd10, '0);
      send(1'b1, 1'b0, 32'd11, '0);
      for (int i = 0; i < 4; i++) expect_acc(1'b0, 1'b0, DW'(i), 32'hA5A5_0000 + i);
      expect_acc(1'b1, 1'b0, 32'd10, 32'hA5A5_000A);
      expect_acc(1'b1, 1'b0, 32'd11, 32'hA5A5_000B);
      expect_acc(1'b0, 1'b0, 32'd4, 32'hA5A5_0004);
      expect_acc(1'b0, 1'b0, 32'd5, 32'hDEAD_BEEF);
      wait_drain("s3", 40);

      // Uncontested stream of ten writes: back-to-back acks, hold saturates.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         send(1'b1, 1'b1, DW'(i), 32'hB000_0000 + i);
         expect_acc(1'b1, 1'b1, DW'(i), 32'hB000_0000 + i);
      end
      wait_ack("s4", 1'b1, 10);
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         #1 chk("s4_no_gap", ack1, 1'b1);
      end
      wait_drain("s4", 20);

      // Write from port 1, then port 0 reads the same word.
      do_reset();
      send(1'b1, 1'b1, 32'd9, 32'h0000_1234);
      expect_acc(1'b1, 1'b1, 32'd9, 32'h0000_1234);
      expect_acc(1'b0, 1'b0, 32'd9, 32'h0000_1234);
      @(negedge clk);
      #1 send(1'b0, 1'b0, 32'd9, '0);
      wait_drain("s5", 20);

      // Reset while read data is being returned, then re-serve from idle.
      do_reset();
      send(1'b0, 1'b0, 32'd3, '0);
      expect_acc(1'b0, 1'b0, 32'd3, 32'hB000_0003);
      wait_ack("s6", 1'b0, 10);
      @(posedge clk);
      #2 chk("s6_rvalid0_before_reset", rvalid0, 1'b1);
      chk("s6_rdata0_before_reset", rdata0, 32'hB000_0003);
      reset = 1'b0;
      #1 chk("s6_rvalid0_killed", rvalid0, 1'b0);
      chk("s6_rdata0_cleared", rdata0, '0);
      chk("s6_mem_quiet", {mem_read_enable, mem_write_enable, ack0, ack1}, '0);
      chk("s6_mem_bus_zero", {mem_address, mem_in_data}, '0);
      @(negedge clk);
      #1 reset = 1'b1;
      send(1'b0, 1'b0, 32'd4, '0);
      expect_acc(1'b0, 1'b0, 32'd4, 32'hB000_0004);
      check_latency("s6_rearm", 1'b0);
      wait_drain("s6", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
